sfft_frame_buffer: RTL

Parametrised, double-buffered capture of SFFT output frames for host readout over the memory-mapped driver bus. Bins arrive as a serial stream from the SFFT pipeline into a write bank. A complete, well-formed frame is published to the host bank only when the host has released the previous frame. It replaces the single-bank snapshot readout in the accelerator top level, and adds frame handshaking, drop and error accounting, and programmable scaling.

---
 rtl/sfft_frame_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/sfft_frame_buffer.sv
// rtl/sfft_frame_buffer.sv - double-buffered SFFT frame capture with host readout
// Bins stream into the write bank; well-formed frames are published by a bank swap.
module sfft_frame_buffer #(
  parameter int NBINS      = 256,
  parameter int IN_WIDTH   = 24,
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  frame_ready
);
  localparam int IW = $clog2(NBINS);

  logic [31:0]          mem [0:2*NBINS-1];
  logic                 wr_bank;
  logic [IW:0]          idx;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [15:0]          drop_cnt;
  logic [15:0]          err_cnt;
  logic [4:0]           shift;

  logic host_wr, release_req, clear_req, frame_end, well_formed;
  logic publish, drop, error;
  logic [ADDR_WIDTH-1:0] bin_off;
  logic unused_bits;

  assign host_wr     = chipselect & write & (address == ADDR_WIDTH'(2));
  assign release_req = host_wr & writedata[0];
  assign clear_req   = host_wr & writedata[6];
  assign frame_end   = in_valid & in_last;
  // idx saturates at NBINS, so an overrun frame can never look like NBINS-1 here
  assign well_formed = (idx == (IW+1)'(NBINS-1));
  assign publish     = frame_end & well_formed & (~frame_ready | release_req);
  assign drop        = frame_end & well_formed & frame_ready & ~release_req;
  assign error       = frame_end & ~well_formed;
  assign bin_off     = address - ADDR_WIDTH'(4);
  assign unused_bits = ^{writedata[31:7], bin_off[ADDR_WIDTH-1:IW], err_cnt[15]};

  always_ff @(posedge clk) begin
    if (in_valid && !idx[IW])
      mem[{wr_bank, idx[IW-1:0]}] <= 32'(in_data) >> shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank     <= 1'b0;
      idx         <= '0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      err_cnt     <= '0;
      shift       <= '0;
      frame_ready <= 1'b0;
    end else begin
      if (frame_end)
        idx <= '0;
      else if (in_valid && !idx[IW])
        idx <= idx + (IW+1)'(1);

      if (publish) begin
        wr_bank   <= ~wr_bank;
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      end

      if (publish)
        frame_ready <= 1'b1;
      else if (release_req)
        frame_ready <= 1'b0;

      if (clear_req)
        drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;

      if (clear_req)
        err_cnt <= '0;
      else if (error && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;

      if (host_wr)
        shift <= writedata[5:1];
    end
  end

  // Host reads always see the bank opposite the one being written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (address == ADDR_WIDTH'(0)) begin
      readdata <= 32'(frame_cnt);
    end else if (address == ADDR_WIDTH'(1)) begin
      readdata <= {drop_cnt, err_cnt[14:0], frame_ready};
    end else if (address == ADDR_WIDTH'(2)) begin
      readdata <= {26'b0, shift, frame_ready};
    end else if (address == ADDR_WIDTH'(3)) begin
      readdata <= 32'h5FF7_0000 | 32'(NBINS);
    end else if (address < ADDR_WIDTH'(NBINS + 4)) begin
      readdata <= mem[{~wr_bank, bin_off[IW-1:0]}];
    end else begin
      readdata <= '0;
    end
  end
endmodule
